fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
- PC register and instruction-fetch sequencer for the multi-cycle MIPS CPU.
- Owns the architectural fetch PC and issues one request at a time to a variable-latency instruction memory.
- Holds each returned instruction until decode accepts it, then advances to PC+4 or to the redirect target computed by the next-PC logic.
- Discards stale responses when a redirect arrives mid-fetch.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset; first fetch address.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_req  output  1  request strobe, one cycle per fetch.
imem_addr  output  32  fetch address, valid while imem_req=1.
imem_rvalid  input  1  response valid; at least 1 cycle after the request cycle.
imem_rdata  input  32  instruction word, valid with imem_rvalid.
stall  input  1  decode cannot accept this cycle.
redirect_valid  input  1  next-PC logic supplies a non-sequential target.
redirect_pc  input  32  target PC.
if_valid  output  1  if_pc/if_instr hold a valid instruction.
if_pc  output  32  PC of the presented instruction.
if_instr  output  32  presented instruction word.
misalign  output  1  one-cycle pulse: accepted redirect_pc[1:0]!=0.
fetch_cnt  output  32  count of instructions accepted by decode.

Behaviour:
- **Reset (async, rst_n=0):**
  - state=S_BOOT, pc_q=RESET_PC, buf_q=0, drop_q=0, fetch_cnt=0.
  - imem_req=0, imem_addr=0, if_valid=0, misalign=0.
- **Definitions:**
  - accept = if_valid & ~stall.
  - imem_addr = pc_q when imem_req=1, else 0.
  - if_pc = pc_q; if_instr = buf_q.
  - if_valid = 1 only in S_HOLD.
- **S_BOOT:** unconditionally go to S_REQ next cycle. redirect_valid is ignored.
- **S_REQ:** imem_req=1 for exactly one cycle. Go to S_WAIT.
  - If redirect_valid is set in this cycle: the request to the old pc_q is still issued; drop_q<=1; pc_q<=target.
- **S_WAIT:** imem_req=0.
  - On imem_rvalid with drop_q=1: drop_q<=0, discard the data, go to S_REQ (fetch the new pc_q).
  - On imem_rvalid with drop_q=0: buf_q<=imem_rdata, go to S_HOLD.
  - redirect_valid without rvalid in the same cycle: drop_q<=1, pc_q<=target.
  - redirect_valid together with rvalid: discard the data, pc_q<=target, go to S_REQ.
- **S_HOLD:**
  - accept: fetch_cnt+=1 (wraps at 2^32). pc_q<=redirect_valid ? target : pc_q+4 (mod 2^32). Go to S_REQ.
  - stall=1 with redirect_valid: flush. The held instruction is dropped (fetch_cnt unchanged), pc_q<=target, go to S_REQ.
  - stall=1 without redirect: hold everything stable.
- **Redirect target:**
  - target = {redirect_pc[31:2],2'b00}.
  - misalign pulses the cycle after any redirect that is taken (i.e. not ignored in S_BOOT) with redirect_pc[1:0]!=0.
- **Response timing:**
  - imem_rvalid outside S_WAIT is ignored.
  - At most one request is outstanding.
  - Minimum period is 3 cycles per instruction: REQ, WAIT, HOLD.
- **Reset mid-fetch:** the in-flight response after reset release arrives in S_BOOT/S_REQ and is ignored. The memory must not return a response into the new S_WAIT for a pre-reset request; that is the system's responsibility.

Decomposition:
- Shared package `mips_defs`:
  - state encoding: S_BOOT=2'd0, S_REQ=2'd1, S_WAIT=2'd2, S_HOLD=2'd3;
  - RESET_PC default;
  - nPC_sel codes (00 seq, 01 branch, 10 j/jal, 11 jr), used by the integration to derive redirect_valid.
- One natural sub-module: `fetch_cnt_reg`, a 32-bit enable counter with async active-low clear.

Test Plan:
- Reset release, memory latency 1, stall=0 → imem_addr sequence 0x3000, 0x3004, 0x3008 on REQ cycles; if_valid every 3rd cycle; fetch_cnt=3 after 3 accepts.
- Memory latency 4, stall held 5 cycles in S_HOLD with if_instr=0x2408_0001 → if_pc/if_instr stable throughout; then accept → next request to 0x3004.
- Accept with redirect_valid=1, redirect_pc=0x0000_3100 → next imem_addr=0x3100; misalign=0.
- redirect_pc=0x0000_3202 during S_WAIT (latency 3) → stale rdata not presented; next request 0x3200; misalign pulses once; fetch_cnt unchanged.
- S_HOLD, stall=1, redirect_valid=1 to 0x3400 → held instruction dropped; next request 0x3400; fetch_cnt unchanged.
- pc_q=0xFFFF_FFFC accepted without redirect → next imem_addr=0x0000_0000; rst_n pulsed low mid-S_WAIT → outputs zero immediately, next request 0x3000.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// -----------------------------------------------------------------------------
// mips_defs: shared definitions for the multi-cycle MIPS front end.
//   fetch_state_t : fetch sequencer state encoding.
//   npc_sel_t     : next-PC select codes; any non-sequential code raises
//                   redirect_valid at the integration level.
//   RESET_PC_DEF  : default boot PC.
//   align_target  : forces a redirect target onto a word boundary.
// -----------------------------------------------------------------------------
package mips_defs;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_t;

   typedef enum logic [1:0] {
      NPC_SEQ    = 2'b00,
      NPC_BRANCH = 2'b01,
      NPC_JUMP   = 2'b10,
      NPC_JR     = 2'b11
   } npc_sel_t;

   function automatic logic [31:0] align_target(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

   function automatic logic is_redirect(input npc_sel_t sel);
      return sel != NPC_SEQ;
   endfunction

endpackage

// File: rtl/fetch_cnt_reg.sv
// -----------------------------------------------------------------------------
// fetch_cnt_reg: free-running enable counter, wraps at 2^DATA_W.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low clear
//   en    : increment this cycle
//   cnt   : current count
// -----------------------------------------------------------------------------
module fetch_cnt_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic [DATA_W-1:0] cnt
);

   localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/fetch_seq.sv
// -----------------------------------------------------------------------------
// fetch_seq: PC register and instruction-fetch sequencer.
// Issues one fetch at a time to a variable-latency instruction memory, holds
// the returned word until decode accepts it, then advances to PC+4 or to the
// redirect target. Responses belonging to a fetch that was overtaken by a
// redirect are discarded.
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   imem_req/addr     : one-cycle request strobe and its address (0 when idle)
//   imem_rvalid/rdata : memory response
//   stall             : decode cannot accept this cycle
//   redirect_valid/pc : non-sequential next PC from the next-PC logic
//   if_valid/pc/instr : instruction presented to decode
//   misalign          : one-cycle pulse after a taken redirect with pc[1:0]!=0
//   fetch_cnt         : number of instructions accepted by decode
// -----------------------------------------------------------------------------
module fetch_seq
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        misalign,
   output logic [31:0] fetch_cnt
);

   fetch_state_t state_q;
   logic [31:0]  pc_q;
   logic [31:0]  buf_q;
   logic         drop_q;
   logic         misalign_q;

   logic         accept;
   logic         taken;
   logic [31:0]  target;

   assign accept = (state_q == S_HOLD) & ~stall;
   // Redirects are ignored only while booting; everywhere else they update pc_q.
   assign taken  = redirect_valid & (state_q != S_BOOT);
   assign target = align_target(redirect_pc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         buf_q      <= '0;
         drop_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= taken & (redirect_pc[1:0] != 2'b00);
         case (state_q)
            S_BOOT: state_q <= S_REQ;

            S_REQ: begin
               // The request to the old pc_q is already on the bus; mark its
               // response as stale so it is thrown away in S_WAIT.
               state_q <= S_WAIT;
               if (redirect_valid) begin
                  drop_q <= 1'b1;
                  pc_q   <= target;
               end
            end

            S_WAIT: begin
               if (imem_rvalid) begin
                  if (redirect_valid) begin
                     drop_q  <= 1'b0;
                     pc_q    <= target;
                     state_q <= S_REQ;
                  end else if (drop_q) begin
                     drop_q  <= 1'b0;
                     state_q <= S_REQ;
                  end else begin
                     buf_q   <= imem_rdata;
                     state_q <= S_HOLD;
                  end
               end else if (redirect_valid) begin
                  drop_q <= 1'b1;
                  pc_q   <= target;
               end
            end

            S_HOLD: begin
               if (!stall) begin
                  pc_q    <= redirect_valid ? target : pc_q + 32'd4;
                  state_q <= S_REQ;
               end else if (redirect_valid) begin
                  // Flush: the held instruction never reaches decode.
                  pc_q    <= target;
                  state_q <= S_REQ;
               end
            end

            default: state_q <= S_BOOT;
         endcase
      end
   end

   fetch_cnt_reg #(.DATA_W(32)) u_fetch_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .cnt   (fetch_cnt)
   );

   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = imem_req ? pc_q : 32'd0;
   assign if_valid  = (state_q == S_HOLD);
   assign if_pc     = pc_q;
   assign if_instr  = buf_q;
   assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_fetch_seq: scoreboard bench for fetch_seq. A driver issues stall and
// redirect stimulus and predicts the architectural instruction stream; a
// separate monitor checks what decode actually sees.
// -----------------------------------------------------------------------------
module tb_fetch_seq;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        misalign;
   logic [31:0] fetch_cnt;

   fetch_seq #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .misalign       (misalign),
      .fetch_cnt      (fetch_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Instruction memory contents: a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h2408_3001;
   endfunction

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] cnt;
   } acc_t;

   acc_t        acc_q[$];
   int          mis_q[$];
   int          cyc = 0;
   int          mis_seen = 0;
   logic [31:0] req_log[$];

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory responder ----------------
   int          lat_mode = 1;
   int          pend = 0;
   logic [31:0] pend_addr = 32'd0;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend        = 0;
         imem_rvalid = 1'b0;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(pend_addr);
            end
         end else if (if_valid && $urandom_range(0, 4) == 0) begin
            imem_rvalid = 1'b1;   // stray response while holding
         end
         if (imem_req) begin
            chk("single_outstanding", 32'(pend), 32'd0);
            pend      = (lat_mode == 0) ? int'($urandom_range(1, 5)) : lat_mode;
            pend_addr = imem_addr;
            req_log.push_back(imem_addr);
         end
      end
   end

   // ---------------- monitor ----------------
   bit          hold_prev = 1'b0;
   logic [31:0] hold_pc = 32'd0;
   logic [31:0] hold_instr = 32'd0;

   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         acc_q.delete();
         mis_q.delete();
         hold_prev = 1'b0;
      end else begin
         bit   exp_mis;
         acc_t e;
         if (!imem_req) chk("addr_idle_zero", imem_addr, 32'd0);
         if (hold_prev) begin
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_pc", if_pc, hold_pc);
            chk("hold_instr", if_instr, hold_instr);
         end
         exp_mis = (mis_q.size() > 0) && (mis_q[0] == cyc);
         if (exp_mis) void'(mis_q.pop_front());
         chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
         if (misalign) mis_seen++;
         if (if_valid && !stall) begin
            if (acc_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL accept: got pc %h with no expected entry", if_pc);
            end else begin
               e = acc_q.pop_front();
               chk("accept_pc", if_pc, e.pc);
               chk("accept_instr", if_instr, e.instr);
               chk("accept_cnt_before", fetch_cnt, e.cnt - 32'd1);
            end
         end
         hold_prev  = if_valid && stall && !redirect_valid;
         hold_pc    = if_pc;
         hold_instr = if_instr;
      end
   end

   // ---------------- driver and reference model ----------------
   logic [31:0] pres_pc = RST_PC;   // PC of the instruction decode sees next
   logic [31:0] exp_cnt = 32'd0;
   bit          boot = 1'b0;

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input bit s, input bit rv, input logic [31:0] rpc);
      bit          taken;
      logic [31:0] tgt;
      stall          = s;
      redirect_valid = rv;
      redirect_pc    = rpc;
      taken = rv && !boot;
      tgt   = {rpc[31:2], 2'b00};
      boot  = 1'b0;
      if (taken && rpc[1:0] != 2'b00) mis_q.push_back(cyc + 1);
      if (if_valid && !s) begin
         exp_cnt = exp_cnt + 32'd1;
         acc_q.push_back('{pres_pc, mem_word(pres_pc), exp_cnt});
         pres_pc = taken ? tgt : pres_pc + 32'd4;
      end else if (taken) begin
         pres_pc = tgt;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input bit check_zero);
      stall          = 1'b0;
      redirect_valid = 1'b0;
      rst_n          = 1'b0;
      #1;
      if (check_zero) begin
         chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
         chk("rst_imem_addr", imem_addr, 32'd0);
         chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
         chk("rst_misalign", {31'd0, misalign}, 32'd0);
         chk("rst_fetch_cnt", fetch_cnt, 32'd0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      boot    = 1'b1;
      pres_pc = RST_PC;
      exp_cnt = 32'd0;
      req_log.delete();
   endtask

   task automatic wait_hold();
      int n = 0;
      while (!if_valid && n < 40) begin
         step(1'b1, 1'b0, 32'd0);
         n++;
      end
      if (!if_valid) fail_now("wait_hold");
   endtask

   task automatic run_until_req(output logic [31:0] a);
      int n = 0;
      while (!imem_req && n < 40) begin
         step(1'b0, 1'b0, 32'd0);
         n++;
      end
      if (!imem_req) fail_now("wait_req");
      a = imem_addr;
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] cnt0;
      int          mis0;
      bit          s;
      bit          rv;
      logic [31:0] rpc;

      #2;
      do_reset(1'b1);

      // Latency 1, no stalls; the redirect on the boot cycle must be ignored.
      lat_mode = 1;
      step(1'b0, 1'b1, 32'h0000_5003);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'd0);
      chk("seq_req0", req_log[0], 32'h0000_3000);
      chk("seq_req1", req_log[1], 32'h0000_3004);
      chk("seq_req2", req_log[2], 32'h0000_3008);
      chk("seq_cnt3", fetch_cnt, 32'd3);

      // Latency 4, decode stalls for five cycles on the first word.
      do_reset(1'b0);
      lat_mode = 4;
      wait_hold();
      chk("stall_pc", if_pc, 32'h0000_3000);
      chk("stall_instr", if_instr, 32'h2408_0001);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 32'd0);
         chk("stall_hold_instr", if_instr, 32'h2408_0001);
         chk("stall_hold_pc", if_pc, 32'h0000_3000);
      end
      step(1'b0, 1'b0, 32'd0);
      run_until_req(a);
      chk("after_stall_addr", a, 32'h0000_3004);

      // Accept together with an aligned redirect.
      wait_hold();
      lat_mode = 3;
      mis0 = mis_seen;
      step(1'b0, 1'b1, 32'h0000_3100);
      run_until_req(a);
      chk("accept_redir_addr", a, 32'h0000_3100);
      step(1'b1, 1'b0, 32'd0);
      chk("aligned_no_misalign", 32'(mis_seen), 32'(mis0));

      // Misaligned redirect while waiting on memory.
      cnt0 = fetch_cnt;
      mis0 = mis_seen;
      step(1'b1, 1'b1, 32'h0000_3202);
      run_until_req(a);
      chk("wait_redir_addr", a, 32'h0000_3200);
      chk("wait_redir_cnt", fetch_cnt, cnt0);
      chk("wait_redir_mis_once", 32'(mis_seen), 32'(mis0 + 1));
      wait_hold();
      chk("wait_redir_pc", if_pc, 32'h0000_3200);
      chk("wait_redir_instr", if_instr, mem_word(32'h0000_3200));

      // Flush of a held instruction.
      cnt0 = fetch_cnt;
      step(1'b1, 1'b1, 32'h0000_3400);
      run_until_req(a);
      chk("flush_addr", a, 32'h0000_3400);
      chk("flush_cnt", fetch_cnt, cnt0);

      // PC wrap at the top of the address space.
      wait_hold();
      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      run_until_req(a);
      chk("wrap_top_addr", a, 32'hFFFF_FFFC);
      wait_hold();
      step(1'b0, 1'b0, 32'd0);
      run_until_req(a);
      chk("wrap_zero_addr", a, 32'h0000_0000);

      // Reset while a fetch is in flight.
      step(1'b1, 1'b0, 32'd0);
      do_reset(1'b1);
      run_until_req(a);
      chk("post_reset_addr", a, 32'h0000_3000);

      // Randomized traffic.
      lat_mode = 0;
      for (int i = 0; i < 1500; i++) begin
         s   = ($urandom_range(0, 99) < 35);
         rv  = ($urandom_range(0, 99) < 12);
         rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                           : 32'h0000_3000 + 32'($urandom_range(0, 4095));
         step(s, rv, rpc);
      end
      wait_hold();
      step(1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);
      #3;
      chk("final_acc_q_empty", 32'(acc_q.size()), 32'd0);
      chk("final_mis_q_empty", 32'(mis_q.size()), 32'd0);
      chk("final_fetch_cnt", fetch_cnt, exp_cnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
